// File: rtl/param_transmitter.sv
// rtl/param_transmitter.sv - parameterized serial frame transmitter (start, LSB-first data, optional even parity, stop, gap)
// Supports a legacy level handshake (one frame per Valid assertion) or streaming back-to-back frames.
module param_transmitter #(
  parameter int DATA_W       = 55,
  parameter int PARITY_EN    = 1,
  parameter int CLKS_PER_BIT = 1,
  parameter int GAP_BITS     = 1,
  parameter int HS_MODE      = 0
) (
  input  logic              Clk_S,
  input  logic              Rst_n,
  input  logic [DATA_W-1:0] TX_Data,
  input  logic              TX_Data_Valid,
  output logic              TX_Ready,
  output logic              S_Data,
  output logic              TX_Busy,
  output logic              TX_Done
);

  typedef enum logic [2:0] {
    ARM    = 3'd0,
    IDLE   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5,
    GAP    = 3'd6
  } state_t;

  localparam logic [7:0] CPB_M1   = 8'(CLKS_PER_BIT - 1);
  localparam logic [6:0] LAST_IDX = 7'(DATA_W - 1);
  localparam logic [6:0] GAP_M1   = 7'(GAP_BITS - 1);

  state_t            state;
  logic [7:0]        bit_cnt;
  logic [6:0]        bit_idx;
  logic [DATA_W-1:0] shreg;
  logic              parity;
  logic              bit_end;
  logic              frame_end;
  logic              accept;

  assign TX_Ready = (state == IDLE);

  // In streaming mode a payload already waiting at frame end is taken on that
  // boundary, so consecutive frames are separated by the gap and nothing else.
  always_comb begin
    bit_end   = (bit_cnt == 8'd0);
    frame_end = bit_end && (((state == STOP) && (GAP_BITS == 0)) ||
                            ((state == GAP) && (bit_idx == GAP_M1)));
    accept    = TX_Data_Valid && ((state == IDLE) || ((HS_MODE != 0) && frame_end));
  end

  always_ff @(posedge Clk_S or negedge Rst_n) begin
    if (!Rst_n) begin
      state   <= ARM;
      S_Data  <= 1'b1;
      TX_Busy <= 1'b0;
      TX_Done <= 1'b0;
      bit_cnt <= 8'd0;
      bit_idx <= 7'd0;
      shreg   <= '0;
      parity  <= 1'b0;
    end else begin
      TX_Done <= 1'b0;
      case (state)
        ARM: begin
          S_Data <= 1'b1;
          if (!TX_Data_Valid) state <= IDLE;
        end
        IDLE: S_Data <= 1'b1;
        START: begin
          if (bit_end) begin
            state   <= DATA;
            S_Data  <= shreg[0];
            shreg   <= shreg >> 1;
            bit_idx <= 7'd0;
            bit_cnt <= CPB_M1;
          end else begin
            bit_cnt <= bit_cnt - 8'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            bit_cnt <= CPB_M1;
            if (bit_idx == LAST_IDX) begin
              if (PARITY_EN != 0) begin
                state  <= PARITY;
                S_Data <= parity;
              end else begin
                state  <= STOP;
                S_Data <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 7'd1;
              S_Data  <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end else begin
            bit_cnt <= bit_cnt - 8'd1;
          end
        end
        PARITY: begin
          if (bit_end) begin
            state   <= STOP;
            S_Data  <= 1'b1;
            bit_cnt <= CPB_M1;
          end else begin
            bit_cnt <= bit_cnt - 8'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            TX_Done <= 1'b1;
            state   <= GAP;
            bit_idx <= 7'd0;
            bit_cnt <= CPB_M1;
          end else begin
            bit_cnt <= bit_cnt - 8'd1;
          end
        end
        GAP: begin
          if (bit_end) begin
            bit_idx <= bit_idx + 7'd1;
            bit_cnt <= CPB_M1;
          end else begin
            bit_cnt <= bit_cnt - 8'd1;
          end
        end
        default: begin
          state   <= ARM;
          S_Data  <= 1'b1;
          TX_Busy <= 1'b0;
        end
      endcase

      // Frame end and accept take priority over the per-state updates above.
      if (frame_end) begin
        TX_Busy <= 1'b0;
        state   <= (HS_MODE != 0) ? IDLE : ARM;
      end
      if (accept) begin
        state   <= START;
        S_Data  <= 1'b0;
        shreg   <= TX_Data;
        parity  <= ^TX_Data;
        bit_cnt <= CPB_M1;
        TX_Busy <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_param_transmitter.sv
// tb/tb_param_transmitter.sv - randomized, model-checked bench for param_transmitter in three configurations
module tb_param_transmitter;

  localparam int P_EN [3] = '{1, 1, 0};
  localparam int CPB  [3] = '{2, 2, 1};
  localparam int GAPB [3] = '{1, 1, 0};
  localparam int HSM  [3] = '{0, 1, 1};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vld [3];
  logic [7:0] dat [3];
  logic       rdy [3];
  logic       sd  [3];
  logic       bsy [3];
  logic       dn  [3];

  int errors = 0;
  int checks = 0;

  // Model: cycle offset into the current frame (-1 = none), payload, and handshake phase.
  int         mk    [3];
  logic [7:0] md    [3];
  bit         marm  [3];
  bit         midle [3];
  bit         mdone [3];

  always #5 clk = ~clk;

  param_transmitter #(.DATA_W(8), .PARITY_EN(1), .CLKS_PER_BIT(2), .GAP_BITS(1), .HS_MODE(0)) u_lvl (
    .Clk_S(clk), .Rst_n(rst_n), .TX_Data(dat[0]), .TX_Data_Valid(vld[0]),
    .TX_Ready(rdy[0]), .S_Data(sd[0]), .TX_Busy(bsy[0]), .TX_Done(dn[0]));

  param_transmitter #(.DATA_W(8), .PARITY_EN(1), .CLKS_PER_BIT(2), .GAP_BITS(1), .HS_MODE(1)) u_hs (
    .Clk_S(clk), .Rst_n(rst_n), .TX_Data(dat[1]), .TX_Data_Valid(vld[1]),
    .TX_Ready(rdy[1]), .S_Data(sd[1]), .TX_Busy(bsy[1]), .TX_Done(dn[1]));

  param_transmitter #(.DATA_W(8), .PARITY_EN(0), .CLKS_PER_BIT(1), .GAP_BITS(0), .HS_MODE(1)) u_fast (
    .Clk_S(clk), .Rst_n(rst_n), .TX_Data(dat[2]), .TX_Data_Valid(vld[2]),
    .TX_Ready(rdy[2]), .S_Data(sd[2]), .TX_Busy(bsy[2]), .TX_Done(dn[2]));

  function automatic int frame_len(int i);
    return (2 + 8 + P_EN[i]) * CPB[i];
  endfunction

  function automatic int total_len(int i);
    return frame_len(i) + GAPB[i] * CPB[i];
  endfunction

  function automatic logic exp_sd(int i);
    int b;
    logic [7:0] d;
    if (mk[i] < 0 || mk[i] >= frame_len(i)) return 1'b1;
    b = mk[i] / CPB[i];
    d = md[i];
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (P_EN[i] != 0 && b == 9) return ^d;
    return 1'b1;
  endfunction

  task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst=%0d got=%0h want=%0h at %0t", name, inst, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mk[i] = -1; md[i] = 8'h00; marm[i] = 1'b1; midle[i] = 1'b0; mdone[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    bit nd;
    for (int i = 0; i < 3; i++) begin
      nd = (mk[i] == frame_len(i) - 1);
      if (mk[i] >= 0) begin
        if (mk[i] == total_len(i) - 1) begin
          if (HSM[i] != 0 && vld[i]) begin
            mk[i] = 0; md[i] = dat[i];
          end else begin
            mk[i] = -1;
            if (HSM[i] != 0) midle[i] = 1'b1; else marm[i] = 1'b1;
          end
        end else begin
          mk[i]++;
        end
      end else if (marm[i]) begin
        if (!vld[i]) begin marm[i] = 1'b0; midle[i] = 1'b1; end
      end else if (midle[i] && vld[i]) begin
        midle[i] = 1'b0; mk[i] = 0; md[i] = dat[i];
      end
      mdone[i] = nd;
    end
  endtask

  task automatic model_loop();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset(); else model_step();
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        check("ready",  i, rdy[i], midle[i]);
        check("s_data", i, sd[i],  exp_sd(i));
        check("busy",   i, bsy[i], mk[i] >= 0);
        check("done",   i, dn[i],  mdone[i]);
      end
    end
  endtask

  initial begin
    logic [43:0] ca, cb, cc, da;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin vld[i] = 1'b1; dat[i] = 8'($urandom); end
    model_reset();
    fork
      model_loop();
      compare_loop();
    join_none

    // Release reset with Valid high: everyone must stay armed.
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("arm_ready", i, rdy[i], 1'b0);
      check("arm_line",  i, sd[i],  1'b1);
    end
    @(posedge clk);
    #1 for (int i = 0; i < 3; i++) vld[i] = 1'b0;
    @(posedge clk);
    #1 for (int i = 0; i < 3; i++) vld[i] = 1'b1;
    dat[0] = 8'hA5; dat[1] = 8'h01; dat[2] = 8'($urandom);
    @(negedge clk);
    for (int i = 0; i < 3; i++) check("idle_ready", i, rdy[i], 1'b1);
    @(posedge clk);
    for (int c = 0; c < 44; c++) begin
      #1 dat[0] = 8'($urandom); dat[1] = 8'hFF; dat[2] = 8'($urandom);
      @(negedge clk);
      ca[c] = sd[0]; cb[c] = sd[1]; cc[c] = sd[2]; da[c] = dn[0];
      @(posedge clk);
    end
    check("a5_frame",    0, 32'(ca[21:0]), 32'(22'b1100110011000011001100));
    check("a5_gap",      0, 32'(ca[23:22]), 32'(2'b11));
    check("a5_done",     0, 32'(da[23:20]), 32'(4'b0100));
    check("hs_data1",    1, 32'(cb[17:2]), 32'h0003);
    check("hs_par1",     1, 32'(cb[19:18]), 32'(2'b11));
    check("hs_stopgap",  1, 32'(cb[23:20]), 32'(4'b1111));
    check("hs_start2",   1, 32'(cb[25:24]), 32'(2'b00));
    check("hs_data2",    1, 32'(cb[41:26]), 32'hFFFF);
    check("hs_par2",     1, 32'(cb[43:42]), 32'(2'b00));
    check("fast_period", 2, 32'({cc[0], cc[9], cc[10], cc[19], cc[20]}), 32'(5'b01010));

    // Abort a level-mode frame during data bit 3.
    #1 vld[0] = 1'b0;
    @(posedge clk);
    #1 vld[0] = 1'b1;
    @(posedge clk);
    repeat (8) @(posedge clk);
    #2 check("busy_pre", 0, bsy[0], 1'b1);
    #1 rst_n = 1'b0;
    #1 check("rst_line", 0, sd[0], 1'b1);
    check("rst_busy", 0, bsy[0], 1'b0);
    check("rst_done", 0, dn[0], 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 7) == 0) vld[i] = ~vld[i];
        dat[i] = 8'($urandom);
      end
      if (n % 700 == 350) #2 rst_n = 1'b0;
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/param_transmitter.md
PARAM_TRANSMITTER -- requirements
Module: param_transmitter

Interface
REQ-001 Parameter DATA_W, default 55, payload width in bits (legal 1..64).
REQ-002 Parameter PARITY_EN, default 1, 1 appends an even-parity bit after the payload, 0 omits it.
REQ-003 Parameter CLKS_PER_BIT, default 1, Clk_S cycles each serial bit is held (legal 1..256).
REQ-004 Parameter GAP_BITS, default 1, idle-high bit times forced after each stop bit (legal 0..15).
REQ-005 Parameter HS_MODE, default 0: 0 = legacy level handshake, 1 = streaming valid/ready.
REQ-006 Clk_S  input  1  sole clock, all state on its rising edge.
REQ-007 Rst_n  input  1  asynchronous, active-low reset.
REQ-008 TX_Data  input  DATA_W  payload, sampled only on the accept edge.
REQ-009 TX_Data_Valid  input  1  payload present.
REQ-010 TX_Ready  output  1  block can accept a payload this cycle.
REQ-011 S_Data  output  1  registered serial line, idles high.
REQ-012 TX_Busy  output  1  high from accept edge until the gap completes.
REQ-013 TX_Done  output  1  one-cycle pulse after the stop bit's last cycle.

Function
REQ-014 States: ARM, IDLE, START, DATA, PARITY, STOP, GAP; state held in a binary-encoded register.
REQ-015 TX_Ready shall be 1 only in IDLE, decoded combinationally from state.
REQ-016 Accept edge = rising Clk_S with state IDLE and TX_Data_Valid=1; TX_Data latched into shift register, parity computed from the latched value, state -> START.
REQ-017 S_Data shall be registered: 0 during START, payload LSB first during DATA, even parity (XOR of payload) during PARITY, 1 during STOP, GAP, IDLE, ARM.
REQ-018 Each of START, each DATA bit, PARITY, STOP shall last exactly CLKS_PER_BIT cycles, counted by a bit-time counter reloaded on every bit boundary.
REQ-019 DATA shall hold for DATA_W bit times, tracked by a bit index counter; PARITY is skipped when PARITY_EN=0.
REQ-020 First S_Data=0 cycle shall be the cycle after the accept edge; frame length = (2+DATA_W+PARITY_EN)*CLKS_PER_BIT cycles.
REQ-021 TX_Done shall assert for exactly the one cycle following the final STOP cycle.
REQ-022 GAP shall last GAP_BITS*CLKS_PER_BIT cycles; GAP_BITS=0 shall go STOP -> next state directly.
REQ-023 HS_MODE=0: after STOP/GAP, state -> ARM; ARM -> IDLE only on a cycle with TX_Data_Valid=0, so one payload is sent per Valid assertion.
REQ-024 HS_MODE=1: after STOP/GAP, state -> IDLE; Valid held high shall start a new frame on the first IDLE cycle, giving back-to-back frames separated only by GAP.
REQ-025 TX_Data and TX_Data_Valid changes outside the accept edge shall not affect the frame in flight.
REQ-026 Illegal state encodings shall return to ARM on the next edge with S_Data=1.

Reset
REQ-027 Rst_n=0 shall immediately force state=ARM, S_Data=1, TX_Ready=0, TX_Busy=0, TX_Done=0, all counters and shift register to 0.
REQ-028 Reset mid-frame shall abort the frame with no further bits emitted; after release the block follows ARM rules in both modes (Valid must be seen low once).

Verification
REQ-029 DATA_W=8, PARITY_EN=1, CLKS_PER_BIT=2, GAP_BITS=1, HS_MODE=0: release reset with Valid=0, assert Valid with 8'hA5 -> S_Data 0,0 then 1,0,1,0,0,1,0,1 each 2 cycles, parity 0 for 2 cycles, stop 1 for 2 cycles, TX_Done one cycle, TX_Ready low until Valid drops.
REQ-030 Same config, HS_MODE=1, Valid held high with 8'h01 then 8'hFF -> two frames, 2 idle-high cycles between stop and next start, parities 1 then 0.
REQ-031 PARITY_EN=0, GAP_BITS=0, CLKS_PER_BIT=1, HS_MODE=1, DATA_W=8, continuous Valid -> frame every 10 cycles, no extra idle cycle.
REQ-032 Release reset with Valid=1 in HS_MODE=0 -> TX_Ready stays 0 and S_Data stays 1 until Valid drops for one cycle.
REQ-033 Assert Rst_n=0 during DATA bit 3 -> S_Data=1 and TX_Busy=0 asynchronously, no TX_Done pulse.
REQ-034 Change TX_Data every cycle during a frame -> serialized bits match only the value present on the accept edge.
